// File: rtl/mmio_responder_if.sv
// Processor-side data-memory bus seen by the MMIO responder.
// The slave modport is the responder; the master modport is the processor
// together with the backing data RAM, which supplies q_ram and consumes ram_wren.
interface mmio_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic        ren;
  logic [31:0] q_ram;
  logic        ram_wren;
  logic [31:0] q_dmem;

  modport slave (
    input  address_dmem,
    input  data,
    input  wren,
    input  ren,
    input  q_ram,
    output ram_wren,
    output q_dmem
  );

  modport master (
    output address_dmem,
    output data,
    output wren,
    output ren,
    output q_ram,
    input  ram_wren,
    input  q_dmem
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder sitting beside the data RAM.
// It decodes address bits [13:12] into RAM / IO-write / IO-read / invalid regions.
// It holds the GPIO and two-channel PWM registers that drive the PMOD header,
// and it returns RAM or IO-read data to the processor.
module mmio_responder (
  input  logic               clock,
  input  logic               reset,
  mmio_responder_if.slave    bus,
  output logic [5:0]         JA
);

  localparam logic [1:0] REGION_RAM  = 2'b00;
  localparam logic [1:0] REGION_IOWR = 2'b01;
  localparam logic [1:0] REGION_IORD = 2'b10;

  logic [1:0]  region;
  logic [2:0]  idx;
  logic        io_write;
  logic        wrap_clr;
  logic        unused_bits;

  logic [5:0]  out_bits;
  logic [5:0]  mode_bits;
  logic [19:0] period_sh;
  logic [19:0] duty0_sh;
  logic [19:0] duty1_sh;
  logic [19:0] period;
  logic [19:0] duty0;
  logic [19:0] duty1;
  logic [19:0] cnt;
  logic [19:0] cnt_next;
  logic        wrap_evt;
  logic        load_active;
  logic        wrap_flag;
  logic [31:0] cyc;
  logic        pwm0;
  logic        pwm1;
  logic [5:0]  ja_next;

  assign region      = bus.address_dmem[13:12];
  assign idx         = bus.address_dmem[2:0];
  assign io_write    = bus.wren && (region == REGION_IOWR);
  assign wrap_clr    = bus.ren && (region == REGION_IORD) && (idx == 3'd2);
  assign unused_bits = ^{bus.address_dmem[31:14], bus.address_dmem[11:3], bus.data[31:20]};

  // Only RAM-region stores reach the RAM, and never while reset is held
  always_comb begin
    bus.ram_wren = bus.wren && (region == REGION_RAM) && !reset;
  end

  // PWM counter sequencing: wrap detection, next count, shadow-load strobe
  always_comb begin
    wrap_evt    = (period != 20'd0) && (cnt == (period - 20'd1));
    load_active = wrap_evt || (period == 20'd0);
    if (period == 20'd0) begin
      cnt_next = 20'd0;
    end else if (wrap_evt) begin
      cnt_next = 20'd0;
    end else begin
      cnt_next = cnt + 20'd1;
    end
  end

  // PWM outputs and the next header value; only pins 0 and 1 can carry PWM
  always_comb begin
    pwm0    = (period != 20'd0) && (cnt < duty0);
    pwm1    = (period != 20'd0) && (cnt < duty1);
    ja_next = {out_bits[5:2],
               mode_bits[1] ? pwm1 : out_bits[1],
               mode_bits[0] ? pwm0 : out_bits[0]};
  end

  // IO-write registers; a later write to the same index simply overwrites
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_bits  <= 6'd0;
      mode_bits <= 6'd0;
      period_sh <= 20'd0;
      duty0_sh  <= 20'd0;
      duty1_sh  <= 20'd0;
    end else if (io_write) begin
      case (idx)
        3'd0:    out_bits  <= bus.data[5:0];
        3'd1:    mode_bits <= bus.data[5:0];
        3'd2:    period_sh <= bus.data[19:0];
        3'd3:    duty0_sh  <= bus.data[19:0];
        3'd4:    duty1_sh  <= bus.data[19:0];
        default: ;
      endcase
    end else begin
      out_bits <= out_bits;
    end
  end

  // Active PWM settings. They follow the shadows only at a period wrap,
  // or continuously while the PWM is stopped, so a running period is never torn.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period <= 20'd0;
      duty0  <= 20'd0;
      duty1  <= 20'd0;
    end else if (load_active) begin
      period <= period_sh;
      duty0  <= duty0_sh;
      duty1  <= duty1_sh;
    end else begin
      period <= period;
    end
  end

  // PWM counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 20'd0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // Sticky wrap flag: a wrap in the same cycle as a clearing read keeps it set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap_flag <= 1'b0;
    end else if (wrap_evt) begin
      wrap_flag <= 1'b1;
    end else if (wrap_clr) begin
      wrap_flag <= 1'b0;
    end else begin
      wrap_flag <= wrap_flag;
    end
  end

  // Free-running cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc <= 32'd0;
    end else begin
      cyc <= cyc + 32'd1;
    end
  end

  // Registered PMOD header
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      JA <= 6'd0;
    end else begin
      JA <= ja_next;
    end
  end

  // Load data mux: RAM pass-through, IO-read registers, zero elsewhere
  always_comb begin
    bus.q_dmem = 32'd0;
    case (region)
      REGION_RAM: bus.q_dmem = bus.q_ram;
      REGION_IORD: begin
        case (idx)
          3'd0:    bus.q_dmem = {26'd0, JA};
          3'd1:    bus.q_dmem = {12'd0, cnt};
          3'd2:    bus.q_dmem = {31'd0, wrap_flag};
          3'd3:    bus.q_dmem = cyc;
          default: bus.q_dmem = 32'd0;
        endcase
      end
      default: bus.q_dmem = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder.
`timescale 1ns/1ps
module tb_mmio_responder;

  logic       clock;
  logic       reset;
  logic [5:0] JA;
  int         n_checks;
  int         n_fail;

  mmio_responder_if bus();

  mmio_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .JA    (JA)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = w;
    bus.ren          = r;
  endtask

  task automatic test_reset();
    @(negedge clock);
    drive(32'h0000_0040, 32'h0000_0011, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.ram_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ram_wren: got %b expected 0", bus.ram_wren);
    end
    n_checks++;
    if (JA !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ja: got %h expected 00", JA);
    end
    drive(32'h0000_2001, 32'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h expected 0", bus.q_dmem);
    end
    drive(32'h0000_2003, 32'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cyc: got %h expected 0", bus.q_dmem);
    end
    @(negedge clock);
    reset = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_ram();
    @(negedge clock);
    drive(32'h0000_0040, 32'h1234_5678, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.ram_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL ram_store_wren: got %b expected 1", bus.ram_wren);
    end
    @(negedge clock);
    drive(32'h0000_0040, 32'd0, 1'b0, 1'b1);
    bus.q_ram = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL ram_load: got %h expected cafef00d", bus.q_dmem);
    end
    drive(32'h0000_1000, 32'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin
      n_fail++;
      $display("FAIL iowr_region_read: got %h expected 0", bus.q_dmem);
    end
    drive(32'h0000_3040, 32'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin
      n_fail++;
      $display("FAIL invalid_region_read: got %h expected 0", bus.q_dmem);
    end
  endtask

  task automatic test_io();
    @(negedge clock);
    drive(32'h0000_1000, 32'h0000_002A, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.ram_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL io_ram_wren: got %b expected 0", bus.ram_wren);
    end
    @(negedge clock);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (JA !== 6'd0) begin
      n_fail++;
      $display("FAIL io_ja_latency: got %h expected 00", JA);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (JA !== 6'b101010) begin
      n_fail++;
      $display("FAIL io_ja: got %b expected 101010", JA);
    end
    drive(32'h0000_2000, 32'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'h0000_002A) begin
      n_fail++;
      $display("FAIL io_read_ja: got %h expected 0000002a", bus.q_dmem);
    end
    @(negedge clock);
    drive(32'h0000_3000, 32'h0000_0015, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.ram_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_ram_wren: got %b expected 0", bus.ram_wren);
    end
    @(negedge clock);
    drive(32'h0000_2000, 32'h0000_0015, 1'b1, 1'b1);
    @(negedge clock);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    n_checks++;
    if (JA !== 6'b101010) begin
      n_fail++;
      $display("FAIL stray_write_ja: got %b expected 101010", JA);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    drive(32'h0000_1000, 32'h0000_0001, 1'b1, 1'b1);
    @(negedge clock);
    drive(32'h0000_1000, 32'hFFFF_FFC2, 1'b1, 1'b1);
    @(negedge clock);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (JA !== 6'h01) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected 01", JA);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (JA !== 6'h02) begin
      n_fail++;
      $display("FAIL b2b_last_wins: got %h expected 02", JA);
    end
  endtask

  task automatic test_pwm();
    int hi;
    int maxc;
    @(negedge clock);
    drive(32'h0000_1001, 32'h0000_0001, 1'b1, 1'b0);
    @(negedge clock);
    drive(32'h0000_1003, 32'd3, 1'b1, 1'b0);
    @(negedge clock);
    drive(32'h0000_1002, 32'd10, 1'b1, 1'b0);
    @(negedge clock);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    maxc = 0;
    for (int w = 0; w < 3; w++) begin
      hi = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        drive(32'h0000_2001, 32'd0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.q_dmem > 32'd9) begin
          n_fail++;
          $display("FAIL pwm_cnt_range: got %0d expected 0..9", bus.q_dmem);
        end
        if (int'(bus.q_dmem) > maxc) maxc = int'(bus.q_dmem);
        hi += int'(JA[0]);
      end
      n_checks++;
      if (hi != 3) begin
        n_fail++;
        $display("FAIL pwm_duty_window%0d: got %0d high expected 3", w, hi);
      end
    end
    n_checks++;
    if (maxc != 9) begin
      n_fail++;
      $display("FAIL pwm_cnt_max: got %0d expected 9", maxc);
    end
  endtask

  task automatic test_shadow();
    bit          found;
    logic [31:0] exp_cnt;
    logic        exp_ja;
    int          prev;
    int          duty;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clock);
      drive(32'h0000_2001, 32'd0, 1'b0, 1'b1);
      #1;
      if (bus.q_dmem == 32'd2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL shadow_sync: got no cnt==2 expected within 20 cycles");
      return;
    end
    drive(32'h0000_1003, 32'd7, 1'b1, 1'b0);
    for (int j = 0; j < 18; j++) begin
      @(negedge clock);
      drive(32'h0000_2001, 32'd0, 1'b0, 1'b1);
      #1;
      exp_cnt = 32'((3 + j) % 10);
      prev    = (2 + j) % 10;
      duty    = (j >= 8) ? 7 : 3;
      exp_ja  = (prev < duty);
      n_checks++;
      if (bus.q_dmem !== exp_cnt) begin
        n_fail++;
        $display("FAIL shadow_cnt[%0d]: got %0d expected %0d", j, bus.q_dmem, exp_cnt);
      end
      n_checks++;
      if (JA[0] !== exp_ja) begin
        n_fail++;
        $display("FAIL shadow_ja0[%0d]: got %b expected %b", j, JA[0], exp_ja);
      end
    end
  endtask

  task automatic wait_cnt(input logic [31:0] target, output bit found);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clock);
      drive(32'h0000_2001, 32'd0, 1'b0, 1'b1);
      #1;
      if (bus.q_dmem == target) found = 1'b1;
    end
  endtask

  task automatic test_wrap();
    bit found;
    wait_cnt(32'd4, found);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wrap_sync4: got no cnt==4 expected within 20 cycles");
      return;
    end
    drive(32'h0000_2002, 32'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd1) begin
      n_fail++;
      $display("FAIL wrap_first_read: got %h expected 1", bus.q_dmem);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_reread: got %h expected 0", bus.q_dmem);
    end
    wait_cnt(32'd9, found);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wrap_sync9: got no cnt==9 expected within 20 cycles");
      return;
    end
    drive(32'h0000_2002, 32'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_coincide_read: got %h expected 0", bus.q_dmem);
    end
    @(negedge clock);
    drive(32'h0000_2002, 32'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd1) begin
      n_fail++;
      $display("FAIL wrap_set_wins: got %h expected 1", bus.q_dmem);
    end
  endtask

  task automatic test_cyc();
    logic [31:0] a;
    @(negedge clock);
    drive(32'h0000_2003, 32'd0, 1'b0, 1'b1);
    #1;
    a = bus.q_dmem;
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (bus.q_dmem - a !== 32'd3) begin
      n_fail++;
      $display("FAIL cyc_step: got %0d expected 3", bus.q_dmem - a);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    drive(32'h0000_1001, 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    drive(32'h0000_1000, 32'h0000_003F, 1'b1, 1'b0);
    @(negedge clock);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    n_checks++;
    if (JA !== 6'h3F) begin
      n_fail++;
      $display("FAIL pre_reset_ja: got %h expected 3f", JA);
    end
    #1;
    reset = 1'b1;
    drive(32'h0000_0040, 32'd5, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (JA !== 6'd0) begin
      n_fail++;
      $display("FAIL async_reset_ja: got %h expected 00", JA);
    end
    n_checks++;
    if (bus.ram_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_ram_wren: got %b expected 0", bus.ram_wren);
    end
    reset = 1'b0;
    drive(32'h0000_2003, 32'd0, 1'b0, 1'b1);
    #0.5;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_cyc: got %h expected 0", bus.q_dmem);
    end
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd3) begin
      n_fail++;
      $display("FAIL post_reset_cyc3: got %0d expected 3", bus.q_dmem);
    end
    drive(32'h0000_2001, 32'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (bus.q_dmem !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_cnt_hold: got %0d expected 0", bus.q_dmem);
    end
    n_checks++;
    if (JA !== 6'd0) begin
      n_fail++;
      $display("FAIL post_reset_ja: got %h expected 00", JA);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.q_ram = 32'd0;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    test_reset();
    test_ram();
    test_io();
    test_back_to_back();
    test_pwm();
    test_shadow();
    test_wrap();
    test_cyc();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
